// File: rtl/en_bit_serializer_if.sv
// Load handshake and serial output bundle for en_bit_serializer.
// The master side supplies words and the slave side transmits them.
interface en_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             en;
    logic             bit_out;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, en, bit_out, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, en, bit_out, busy, done
    );
endinterface

// File: rtl/en_bit_serializer.sv
// Parallel-to-serial transmitter that holds each bit for DIV cycles.
// It strobes en in the last cycle of each bit period for a downstream enabled flop.
module en_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               reset,
    en_bit_serializer_if.slave bus
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    logic             cur_bit;
    logic [WIDTH-1:0] shifted;
    logic             period_end;

    // The bit on the wire is always the head of the shift register.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign cur_bit = shreg_q[WIDTH-1];
            assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign cur_bit = shreg_q[0];
            assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign period_end = (state_q == SEND) && (div_cnt_q == LAST_DIV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    state_d   = SEND;
                    shreg_d   = bus.load_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end
            end
            SEND: begin
                // Divider wrap marks the end of a bit period and advances the word.
                if (div_cnt_q == LAST_DIV) begin
                    div_cnt_d = '0;
                    shreg_d   = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so load inputs never reach them.
    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.busy       = (state_q == SEND);
        bus.en         = period_end;
        bus.bit_out    = (state_q == SEND) && cur_bit;
        bus.done       = period_end && (bit_cnt_q == LAST_BIT);
    end
endmodule

// File: tb/tb_en_bit_serializer.sv
// Runs three serializer configurations side by side against a per-cycle timing model
// derived from the load time and word, with directed scenarios followed by random traffic.
module tb_en_bit_serializer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    en_bit_serializer_if #(.WIDTH(8)) if0 ();
    en_bit_serializer_if #(.WIDTH(8)) if1 ();
    en_bit_serializer_if #(.WIDTH(4)) if2 ();

    en_bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    en_bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    en_bit_serializer #(.WIDTH(4), .DIV(2), .MSB_FIRST(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

    bit   [2:0] lv = '0;
    logic [7:0] ld0 = '0;
    logic [7:0] ld1 = '0;
    logic [3:0] ld2 = '0;
    assign if0.load_valid = lv[0];
    assign if1.load_valid = lv[1];
    assign if2.load_valid = lv[2];
    assign if0.load_data  = ld0;
    assign if1.load_data  = ld1;
    assign if2.load_data  = ld2;

    logic [2:0] o_rdy, o_en, o_bit, o_busy, o_done;
    assign o_rdy  = {if2.load_ready, if1.load_ready, if0.load_ready};
    assign o_en   = {if2.en, if1.en, if0.en};
    assign o_bit  = {if2.bit_out, if1.bit_out, if0.bit_out};
    assign o_busy = {if2.busy, if1.busy, if0.busy};
    assign o_done = {if2.done, if1.done, if0.done};

    // Downstream enabled flops fed by the serial stream.
    logic [7:0] cap0 = '0;
    logic [3:0] cap2 = '0;
    always @(posedge clk) begin
        if (if0.en) cap0 <= {cap0[6:0], if0.bit_out};
        if (if2.en) cap2 <= {if2.bit_out, cap2[3:1]};
    end

    int e_cnt = 0;
    always @(posedge clk) e_cnt <= e_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          w;
        int          d;
        int          msb;
        bit          act;
        int          t0;
        logic [31:0] word;
    } mdl_t;
    mdl_t m[3];

    bit   [2:0]  lv_nx = '0;
    logic [31:0] ld_nx[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Cycle n after the load edge: bit (n-1)/DIV in transmit order, en on multiples of DIV.
    function automatic void model(input int i, output bit rdy, output bit en,
                                  output bit b, output bit bsy, output bit dn);
        int n;
        int k;
        int w = m[i].w;
        int d = m[i].d;
        rdy = 1'b1; en = 1'b0; b = 1'b0; bsy = 1'b0; dn = 1'b0;
        if (m[i].act) begin
            n = e_cnt - m[i].t0 + 1;
            if (n >= 1 && n <= w * d) begin
                k   = (n - 1) / d;
                rdy = 1'b0;
                bsy = 1'b1;
                b   = (m[i].msb != 0) ? m[i].word[w-1-k] : m[i].word[k];
                en  = (n % d == 0);
                dn  = (n == w * d);
            end
        end
    endfunction

    task automatic check_all();
        bit r, e, b, bz, d;
        for (int i = 0; i < 3; i++) begin
            model(i, r, e, b, bz, d);
            chk($sformatf("u%0d.load_ready", i), o_rdy[i],  r);
            chk($sformatf("u%0d.en", i),         o_en[i],   e);
            chk($sformatf("u%0d.bit_out", i),    o_bit[i],  b);
            chk($sformatf("u%0d.busy", i),       o_busy[i], bz);
            chk($sformatf("u%0d.done", i),       o_done[i], d);
        end
    endtask

    // Check outputs of the current cycle, then drive the inputs for the next edge.
    task automatic tick();
        bit r, e, b, bz, d;
        logic [31:0] mask;
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) begin
            model(i, r, e, b, bz, d);
            mask = (32'd1 << m[i].w) - 32'd1;
            if (lv_nx[i] && !reset && r) begin
                m[i].act  = 1'b1;
                m[i].t0   = e_cnt + 1;
                m[i].word = ld_nx[i] & mask;
                $display("[TB] u%0d load %0h at cycle %0d", i, m[i].word, e_cnt + 1);
            end
        end
        lv  = lv_nx;
        ld0 = ld_nx[0][7:0];
        ld1 = ld_nx[1][7:0];
        ld2 = ld_nx[2][3:0];
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b1;
        lv    = '0;
        lv_nx = '0;
        for (int i = 0; i < 3; i++) m[i].act = 1'b0;
        #1;
        check_all();
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        m[0] = '{w: 8, d: 4, msb: 1, act: 1'b0, t0: 0, word: 32'd0};
        m[1] = '{w: 8, d: 1, msb: 1, act: 1'b0, t0: 0, word: 32'd0};
        m[2] = '{w: 4, d: 2, msb: 0, act: 1'b0, t0: 0, word: 32'd0};
        for (int i = 0; i < 3; i++) ld_nx[i] = '0;

        // Reset asserted between edges must take effect at once.
        assert_reset();
        tick();
        tick();
        release_reset();
        repeat (3) tick();

        // A5 on u0, 3C then C3 back-to-back on u1, 0001 LSB-first on u2.
        lv_nx = 3'b111;
        ld_nx[0] = 32'hA5; ld_nx[1] = 32'h3C; ld_nx[2] = 32'h1;
        tick();
        lv_nx = 3'b010;
        ld_nx[1] = 32'hC3;
        repeat (10) tick();
        lv_nx = '0;
        repeat (26) tick();
        chk("ds_flop_a5", cap0, 32'hA5);
        chk("ds_flop_lsb", cap2, 32'h1);

        // Load pulse during SEND is ignored.
        lv_nx = 3'b001; ld_nx[0] = 32'hF0;
        tick();
        lv_nx = '0;
        repeat (9) tick();
        lv_nx = 3'b001; ld_nx[0] = 32'h0F;
        tick();
        lv_nx = '0;
        repeat (30) tick();
        chk("ds_flop_f0", cap0, 32'hF0);

        // Abort a transfer with reset, then send a fresh word.
        lv_nx = 3'b001; ld_nx[0] = 32'hFF;
        tick();
        lv_nx = '0;
        repeat (9) tick();
        assert_reset();
        tick();
        tick();
        release_reset();
        tick();
        lv_nx = 3'b001; ld_nx[0] = 32'h81;
        tick();
        lv_nx = '0;
        repeat (36) tick();
        chk("ds_flop_81", cap0, 32'h81);

        // Random traffic with occasional resets.
        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                lv_nx[i] = ($urandom_range(0, 3) == 0);
                ld_nx[i] = $urandom;
            end
            if ($urandom_range(0, 299) == 0) begin
                assert_reset();
                tick();
                release_reset();
            end else begin
                tick();
            end
        end
        lv_nx = '0;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
